stopwatch_ctrl: RTL and testbench



---
 rtl/stopwatch_ctrl_if.sv | 23 ++
 rtl/stopwatch_ctrl.sv | 150 +++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_if.sv
// rtl/stopwatch_ctrl_if.sv - front-panel inputs and counter-control outputs of the stopwatch sequencer
interface stopwatch_ctrl_if;
   logic       btn_pause;
   logic       btn_clear;
   logic       sw_adj;
   logic       sw_sel;
   logic [1:0] state;
   logic       cnt_tick;
   logic       clr;
   logic       tick_1hz;
   logic       tick_2hz;
   logic       blink;

   modport master (
      input  btn_pause, btn_clear, sw_adj, sw_sel,
      output state, cnt_tick, clr, tick_1hz, tick_2hz, blink
   );

   modport slave (
      output btn_pause, btn_clear, sw_adj, sw_sel,
      input  state, cnt_tick, clr, tick_1hz, tick_2hz, blink
   );
endinterface

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch mode FSM with input debounce and 1 Hz / 2 Hz tick generation
// Optional PAUSE_BLINK_EN: blink toggles on tick_2hz while paused; otherwise blink is tied to 1.
module stopwatch_ctrl #(
   parameter int CLK_HZ          = 100000000,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic             clk,
   input  logic             rst_n,
   stopwatch_ctrl_if.master bus
);
   typedef enum logic [1:0] {
      ST_RUN     = 2'b00,
      ST_ADJ_MIN = 2'b01,
      ST_ADJ_SEC = 2'b10,
      ST_PAUSE   = 2'b11
   } state_e;

   localparam int DW  = $clog2(DEBOUNCE_CYCLES);
   localparam int PW  = $clog2(CLK_HZ);
   localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [PW-1:0] P1_MAX = PW'(CLK_HZ - 1);
   localparam logic [PW-1:0] P2_MAX = PW'(CLK_HZ / 2 - 1);

   // Input bit order: 0 pause, 1 clear, 2 adjust, 3 select
   logic [3:0]         raw;
   logic [3:0]         s1_q, s1_d, s2_q, s2_d, deb_q, deb_d;
   logic [3:0][DW-1:0] dcnt_q, dcnt_d;
   logic [1:0]         btn_prev_q, btn_prev_d;
   logic               pause_press, clear_press;

   state_e             state_q, state_d;
   logic [PW-1:0]      p1_q, p1_d, p2_q, p2_d;
   logic               tick1_q, tick1_d, tick2_q, tick2_d;
   logic               clr_q, clr_d;
   logic               run_entry;
   logic               cnt_tick;

   assign raw = {bus.sw_sel, bus.sw_adj, bus.btn_clear, bus.btn_pause};

   always_comb begin
      s1_d       = raw;
      s2_d       = s1_q;
      deb_d      = deb_q;
      dcnt_d     = dcnt_q;
      btn_prev_d = deb_q[1:0];
      for (int i = 0; i < 4; i++) begin
         if (s2_q[i] == deb_q[i]) begin
            dcnt_d[i] = '0;
         end else if (dcnt_q[i] == DB_MAX) begin
            deb_d[i]  = s2_q[i];
            dcnt_d[i] = '0;
         end else begin
            dcnt_d[i] = dcnt_q[i] + DW'(1);
         end
      end
   end

   assign pause_press = deb_q[0] & ~btn_prev_q[0];
   assign clear_press = deb_q[1] & ~btn_prev_q[1];

   // Adjust switch dominates; leaving adjust always parks in PAUSE
   always_comb begin
      state_d = state_q;
      if (deb_q[2]) begin
         state_d = deb_q[3] ? ST_ADJ_SEC : ST_ADJ_MIN;
      end else if (state_q == ST_ADJ_MIN || state_q == ST_ADJ_SEC) begin
         state_d = ST_PAUSE;
      end else if (pause_press) begin
         state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
      end
   end

   // Restarting p1 on RUN entry makes the first counted second a full period
   always_comb begin
      run_entry = (state_d == ST_RUN) && (state_q != ST_RUN);
      p1_d      = (p1_q == P1_MAX || run_entry) ? '0 : p1_q + PW'(1);
      tick1_d   = (p1_q == P1_MAX) && !run_entry;
      p2_d      = (p2_q == P2_MAX) ? '0 : p2_q + PW'(1);
      tick2_d   = (p2_q == P2_MAX);
      clr_d     = clear_press;
   end

   always_comb begin
      cnt_tick = 1'b0;
      case (state_q)
         ST_RUN:                 cnt_tick = tick1_q;
         ST_ADJ_MIN, ST_ADJ_SEC: cnt_tick = tick2_q;
         default:                cnt_tick = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q       <= '0;
         s2_q       <= '0;
         deb_q      <= '0;
         dcnt_q     <= '0;
         btn_prev_q <= '0;
         state_q    <= ST_PAUSE;
         p1_q       <= '0;
         p2_q       <= '0;
         tick1_q    <= 1'b0;
         tick2_q    <= 1'b0;
         clr_q      <= 1'b0;
      end else begin
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         deb_q      <= deb_d;
         dcnt_q     <= dcnt_d;
         btn_prev_q <= btn_prev_d;
         state_q    <= state_d;
         p1_q       <= p1_d;
         p2_q       <= p2_d;
         tick1_q    <= tick1_d;
         tick2_q    <= tick2_d;
         clr_q      <= clr_d;
      end
   end

`ifdef PAUSE_BLINK_EN
   logic blink_q, blink_d;

   always_comb begin
      blink_d = blink_q;
      if (state_d != ST_PAUSE) begin
         blink_d = 1'b1;
      end else if (state_q == ST_PAUSE && tick2_q) begin
         blink_d = ~blink_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_q <= 1'b1;
      end else begin
         blink_q <= blink_d;
      end
   end

   assign bus.blink = blink_q;
`else
   assign bus.blink = 1'b1;
`endif

   assign bus.state    = state_q;
   assign bus.cnt_tick = cnt_tick;
   assign bus.clr      = clr_q;
   assign bus.tick_1hz = tick1_q;
   assign bus.tick_2hz = tick2_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed self-checking bench for stopwatch_ctrl (CLK_HZ=10, DEBOUNCE_CYCLES=4)
module tb_stopwatch_ctrl;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   cyc_n;

   stopwatch_ctrl_if bus ();

   stopwatch_ctrl #(
      .CLK_HZ          (10),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         cyc_n++;
      end
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      bus.btn_pause = 1'b0;
      bus.btn_clear = 1'b0;
      bus.sw_adj    = 1'b0;
      bus.sw_sel    = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      cyc_n = 0;
   endtask

   task automatic go_run();
      bus.btn_pause = 1'b1;
      cyc(8);
      bus.btn_pause = 1'b0;
      cyc(7);
   endtask

   task automatic test_reset();
      logic e1, e2;
      rst_n         = 1'b0;
      bus.btn_pause = 1'b0;
      bus.btn_clear = 1'b0;
      bus.sw_adj    = 1'b0;
      bus.sw_sel    = 1'b0;
      cyc(3);
      checks++;
      if (bus.state !== 2'b11) begin errors++; $display("FAIL reset_state: got %b expected 11", bus.state); end
      checks++;
      if ({bus.cnt_tick, bus.clr, bus.tick_1hz, bus.tick_2hz} !== 4'b0000) begin
         errors++; $display("FAIL reset_pulses: got %b expected 0000", {bus.cnt_tick, bus.clr, bus.tick_1hz, bus.tick_2hz});
      end
      checks++;
      if (bus.blink !== 1'b1) begin errors++; $display("FAIL reset_blink: got %b expected 1", bus.blink); end
      rst_n = 1'b1;
      cyc_n = 0;
      for (int n = 1; n <= 30; n++) begin
         cyc(1);
         e1 = (n % 10 == 0);
         e2 = (n % 5 == 0);
         checks++;
         if (bus.tick_1hz !== e1) begin errors++; $display("FAIL idle_tick_1hz n=%0d: got %b expected %b", n, bus.tick_1hz, e1); end
         checks++;
         if (bus.tick_2hz !== e2) begin errors++; $display("FAIL idle_tick_2hz n=%0d: got %b expected %b", n, bus.tick_2hz, e2); end
         checks++;
         if (bus.cnt_tick !== 1'b0 || bus.state !== 2'b11) begin
            errors++; $display("FAIL idle_pause n=%0d: got state=%b cnt_tick=%b expected 11/0", n, bus.state, bus.cnt_tick);
         end
      end
   endtask

   task automatic test_pause_press();
      logic       et;
      logic [1:0] es;
      do_reset();
      bus.btn_pause = 1'b1;
      for (int n = 1; n <= 37; n++) begin
         cyc(1);
         if (n == 8) bus.btn_pause = 1'b0;
         es = (n >= 7) ? 2'b00 : 2'b11;
         et = (n > 7) && ((n - 7) % 10 == 0);
         checks++;
         if (bus.state !== es) begin errors++; $display("FAIL run_entry_state n=%0d: got %b expected %b", n, bus.state, es); end
         checks++;
         if (bus.tick_1hz !== et || bus.cnt_tick !== et) begin
            errors++; $display("FAIL run_tick n=%0d: got tick_1hz=%b cnt_tick=%b expected %b", n, bus.tick_1hz, bus.cnt_tick, et);
         end
         checks++;
         if (bus.tick_2hz !== (n % 5 == 0)) begin errors++; $display("FAIL run_tick_2hz n=%0d: got %b", n, bus.tick_2hz); end
      end
   endtask

   task automatic test_glitch();
      do_reset();
      bus.btn_pause = 1'b1;
      cyc(3);
      bus.btn_pause = 1'b0;
      for (int n = 4; n <= 14; n++) begin
         cyc(1);
         checks++;
         if (bus.state !== 2'b11 || bus.clr !== 1'b0) begin
            errors++; $display("FAIL glitch n=%0d: got state=%b clr=%b expected 11/0", n, bus.state, bus.clr);
         end
      end
   endtask

   task automatic test_adjust();
      logic [1:0] es;
      logic       et;
      do_reset();
      go_run();
      bus.sw_adj = 1'b1;
      bus.sw_sel = 1'b1;
      while (cyc_n < 36) begin
         cyc(1);
         es = (cyc_n >= 22) ? 2'b10 : 2'b00;
         et = (cyc_n < 22) ? (cyc_n == 17) : (cyc_n % 5 == 0);
         checks++;
         if (bus.state !== es) begin errors++; $display("FAIL adj_sec_state n=%0d: got %b expected %b", cyc_n, bus.state, es); end
         checks++;
         if (bus.cnt_tick !== et) begin errors++; $display("FAIL adj_cnt_tick n=%0d: got %b expected %b", cyc_n, bus.cnt_tick, et); end
      end
      bus.btn_pause = 1'b1;
      while (cyc_n < 52) begin
         cyc(1);
         if (cyc_n == 44) bus.btn_pause = 1'b0;
         checks++;
         if (bus.state !== 2'b10) begin errors++; $display("FAIL adj_pause_ignored n=%0d: got %b expected 10", cyc_n, bus.state); end
      end
      bus.sw_sel = 1'b0;
      while (cyc_n < 60) begin
         cyc(1);
         es = (cyc_n >= 59) ? 2'b01 : 2'b10;
         checks++;
         if (bus.state !== es) begin errors++; $display("FAIL adj_min_state n=%0d: got %b expected %b", cyc_n, bus.state, es); end
      end
      bus.sw_adj = 1'b0;
      while (cyc_n < 70) begin
         cyc(1);
         es = (cyc_n >= 67) ? 2'b11 : 2'b01;
         et = (cyc_n < 67) && (cyc_n % 5 == 0);
         checks++;
         if (bus.state !== es) begin errors++; $display("FAIL adj_exit_state n=%0d: got %b expected %b", cyc_n, bus.state, es); end
         checks++;
         if (bus.cnt_tick !== et) begin errors++; $display("FAIL adj_exit_tick n=%0d: got %b expected %b", cyc_n, bus.cnt_tick, et); end
      end
   endtask

   task automatic test_clear();
      logic [1:0] es;
      do_reset();
      go_run();
      bus.btn_clear = 1'b1;
      while (cyc_n < 31) begin
         cyc(1);
         if (cyc_n == 23) bus.btn_clear = 1'b0;
         checks++;
         if (bus.clr !== (cyc_n == 22)) begin errors++; $display("FAIL clear_pulse n=%0d: got %b expected %b", cyc_n, bus.clr, cyc_n == 22); end
         checks++;
         if (bus.state !== 2'b00) begin errors++; $display("FAIL clear_state n=%0d: got %b expected 00", cyc_n, bus.state); end
      end
      bus.btn_clear = 1'b1;
      bus.btn_pause = 1'b1;
      while (cyc_n < 41) begin
         cyc(1);
         if (cyc_n == 39) begin
            bus.btn_clear = 1'b0;
            bus.btn_pause = 1'b0;
         end
         es = (cyc_n >= 38) ? 2'b11 : 2'b00;
         checks++;
         if (bus.clr !== (cyc_n == 38)) begin errors++; $display("FAIL both_clr n=%0d: got %b expected %b", cyc_n, bus.clr, cyc_n == 38); end
         checks++;
         if (bus.state !== es) begin errors++; $display("FAIL both_state n=%0d: got %b expected %b", cyc_n, bus.state, es); end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      go_run();
      cyc(5);
      checks++;
      if (bus.state !== 2'b00 || bus.tick_2hz !== 1'b1) begin
         errors++; $display("FAIL pre_reset: got state=%b tick_2hz=%b expected 00/1", bus.state, bus.tick_2hz);
      end
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.state !== 2'b11) begin errors++; $display("FAIL async_reset_state: got %b expected 11", bus.state); end
      checks++;
      if ({bus.cnt_tick, bus.clr, bus.tick_1hz, bus.tick_2hz, bus.blink} !== 5'b00001) begin
         errors++; $display("FAIL async_reset_outputs: got %b expected 00001", {bus.cnt_tick, bus.clr, bus.tick_1hz, bus.tick_2hz, bus.blink});
      end
      cyc(1);
   endtask

   task automatic test_blink();
      logic eb;
      do_reset();
      for (int n = 1; n <= 16; n++) begin
         cyc(1);
`ifdef PAUSE_BLINK_EN
         eb = ((n >= 6) ? ((n - 6) / 5 + 1) : 0) % 2 == 0;
`else
         eb = 1'b1;
`endif
         checks++;
         if (bus.blink !== eb) begin errors++; $display("FAIL pause_blink n=%0d: got %b expected %b", n, bus.blink, eb); end
      end
      do_reset();
      go_run();
      for (int n = 0; n < 12; n++) begin
         cyc(1);
         checks++;
         if (bus.blink !== 1'b1 || bus.state !== 2'b00) begin
            errors++; $display("FAIL run_blink n=%0d: got blink=%b state=%b expected 1/00", cyc_n, bus.blink, bus.state);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc_n  = 0;
      rst_n  = 1'b0;
      test_reset();
      test_pause_press();
      test_glitch();
      test_adjust();
      test_clear();
      test_async_reset();
      test_blink();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
